// File: rtl/map_controller.sv
// map_controller: game-logic writer for the 4x4 matching board.
// Owns the tile state vector, cursor and selection, and runs the
// pick-two / compare / hide-on-miss loop from debounced button pulses.
// Optional feature: define CURSOR_WRAP_EN to make cursor moves wrap within
// a row/column instead of saturating at the board edge.
module map_controller #(
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] init_colors,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_pick,
    output logic [79:0] logicMap,
    output logic [3:0]  cursor,
    output logic [9:0]  selected,
    output logic [3:0]  pairs_found,
    output logic        busy,
    output logic        game_done
);

    localparam int CW = $clog2(SHOW_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK1   = 3'd1,
        PICK2   = 3'd2,
        COMPARE = 3'd3,
        SHOW    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [79:0]   map_q, map_d;
    logic [3:0]    cursor_q, cursor_d;
    logic [9:0]    selected_q, selected_d;
    logic [3:0]    pairs_q, pairs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Fresh board image: every tile hidden and unmatched, color from the caller.
    logic [79:0] init_map;
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_init
            assign init_map[5*gi +: 5] = {2'b00, init_colors[3*gi +: 3]};
        end
    endgenerate

    // Bit offsets of the tile under the cursor and of the two selected tiles.
    logic [6:0] cur_base, sel1_base, sel2_base;
    assign cur_base  = {3'b000, cursor_q} * 7'd5;
    assign sel1_base = {3'b000, selected_q[3:0]} * 7'd5;
    assign sel2_base = {3'b000, selected_q[8:5]} * 7'd5;

    logic cur_pickable;
    assign cur_pickable = ~map_q[cur_base + 7'd4] & ~map_q[cur_base + 7'd3];

    logic colors_equal;
    assign colors_equal = (map_q[sel1_base +: 3] == map_q[sel2_base +: 3]);

    // Candidate cursor after one move; up > down > left > right.
    logic [1:0] row_n, col_n;
    always_comb begin
        row_n = cursor_q[3:2];
        col_n = cursor_q[1:0];
`ifdef CURSOR_WRAP_EN
        if (btn_up)         row_n = cursor_q[3:2] - 2'd1;
        else if (btn_down)  row_n = cursor_q[3:2] + 2'd1;
        else if (btn_left)  col_n = cursor_q[1:0] - 2'd1;
        else if (btn_right) col_n = cursor_q[1:0] + 2'd1;
`else
        if (btn_up) begin
            if (cursor_q[3:2] != 2'd0) row_n = cursor_q[3:2] - 2'd1;
        end else if (btn_down) begin
            if (cursor_q[3:2] != 2'd3) row_n = cursor_q[3:2] + 2'd1;
        end else if (btn_left) begin
            if (cursor_q[1:0] != 2'd0) col_n = cursor_q[1:0] - 2'd1;
        end else if (btn_right) begin
            if (cursor_q[1:0] != 2'd3) col_n = cursor_q[1:0] + 2'd1;
        end
`endif
    end

    // Next-state and datapath updates; start overrides whatever is in flight.
    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        cursor_d   = cursor_q;
        selected_d = selected_q;
        pairs_d    = pairs_q;
        cnt_d      = cnt_q;
        if (start) begin
            map_d      = init_map;
            cursor_d   = 4'd0;
            selected_d = 10'd0;
            pairs_d    = 4'd0;
            cnt_d      = '0;
            state_d    = PICK1;
        end else begin
            case (state_q)
                PICK1, PICK2: begin
                    if (btn_pick) begin
                        // A pick freezes the cursor even if the tile is not pickable.
                        if (cur_pickable) begin
                            map_d[cur_base + 7'd3] = 1'b1;
                            if (state_q == PICK1) begin
                                selected_d[4:0] = {1'b1, cursor_q};
                                state_d         = PICK2;
                            end else begin
                                selected_d[9:5] = {1'b1, cursor_q};
                                state_d         = COMPARE;
                            end
                        end
                    end else begin
                        cursor_d = {row_n, col_n};
                    end
                end
                COMPARE: begin
                    if (colors_equal) begin
                        map_d[sel1_base + 7'd4] = 1'b1;
                        map_d[sel2_base + 7'd4] = 1'b1;
                        pairs_d    = pairs_q + 4'd1;
                        selected_d = 10'd0;
                        state_d    = (pairs_q == 4'd7) ? DONE : PICK1;
                    end else begin
                        cnt_d   = CW'(SHOW_CYCLES - 1);
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q == '0) begin
                        map_d[sel1_base + 7'd3] = 1'b0;
                        map_d[sel2_base + 7'd3] = 1'b0;
                        selected_d = 10'd0;
                        state_d    = PICK1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                IDLE, DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == COMPARE) || (state_d == SHOW);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            map_q      <= 80'd0;
            cursor_q   <= 4'd0;
            selected_q <= 10'd0;
            pairs_q    <= 4'd0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            map_q      <= map_d;
            cursor_q   <= cursor_d;
            selected_q <= selected_d;
            pairs_q    <= pairs_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign logicMap    = map_q;
    assign cursor      = cursor_q;
    assign selected    = selected_q;
    assign pairs_found = pairs_q;
    assign busy        = busy_q;
    assign game_done   = done_q;

endmodule

// File: tb/tb_map_controller.sv
// Directed testbench for map_controller with SHOW_CYCLES = 4.
module tb_map_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [47:0] init_colors;
    logic        btn_up, btn_down, btn_left, btn_right, btn_pick;
    logic [79:0] logicMap;
    logic [3:0]  cursor;
    logic [9:0]  selected;
    logic [3:0]  pairs_found;
    logic        busy;
    logic        game_done;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cur_model = 0;
    int exp_pairs = 0;
    logic [79:0] exp_map;

    map_controller #(.SHOW_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .init_colors(init_colors),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_pick(btn_pick),
        .logicMap(logicMap), .cursor(cursor), .selected(selected),
        .pairs_found(pairs_found), .busy(busy), .game_done(game_done)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int dir); // 0 up, 1 down, 2 left, 3 right, 4 pick
        btn_up = (dir == 0); btn_down = (dir == 1); btn_left = (dir == 2);
        btn_right = (dir == 3); btn_pick = (dir == 4);
        step();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_pick = 0;
    endtask

    task automatic goto(input int target);
        while (cur_model / 4 > target / 4) begin press(0); cur_model -= 4; end
        while (cur_model / 4 < target / 4) begin press(1); cur_model += 4; end
        while (cur_model % 4 > target % 4) begin press(2); cur_model -= 1; end
        while (cur_model % 4 < target % 4) begin press(3); cur_model += 1; end
        total_cnt++;
        if (cursor !== 4'(target)) $display("FAIL goto: cursor=%0d expected=%0d", cursor, target);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1; step(); step();
        total_cnt++; if (logicMap !== 80'd0) $display("FAIL reset_map: got=%h expected=0", logicMap); else pass_cnt++;
        total_cnt++; if (cursor !== 4'd0) $display("FAIL reset_cursor: got=%0d expected=0", cursor); else pass_cnt++;
        total_cnt++; if (selected !== 10'd0) $display("FAIL reset_selected: got=%h expected=0", selected); else pass_cnt++;
        total_cnt++; if (pairs_found !== 4'd0) $display("FAIL reset_pairs: got=%0d expected=0", pairs_found); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || game_done !== 1'b0) $display("FAIL reset_flags: busy=%b done=%b expected 0/0", busy, game_done); else pass_cnt++;
        reset = 0; step();
        $display("test_reset done");
    endtask

    task automatic test_start();
        start = 1; step(); start = 0;
        cur_model = 0; exp_pairs = 0;
        total_cnt++; if (logicMap !== exp_map) $display("FAIL start_map: got=%h expected=%h", logicMap, exp_map); else pass_cnt++;
        total_cnt++; if (cursor !== 4'd0 || selected !== 10'd0 || pairs_found !== 4'd0) $display("FAIL start_regs: cursor=%0d sel=%h pairs=%0d expected 0/0/0", cursor, selected, pairs_found); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || game_done !== 1'b0) $display("FAIL start_flags: busy=%b done=%b expected 0/0", busy, game_done); else pass_cnt++;
        $display("test_start done");
    endtask

    task automatic test_move_pick();
        press(3);
        total_cnt++; if (cursor !== 4'd1) $display("FAIL move_right1: got=%0d expected=1", cursor); else pass_cnt++;
        press(3);
        total_cnt++; if (cursor !== 4'd2) $display("FAIL move_right2: got=%0d expected=2", cursor); else pass_cnt++;
        press(1);
        total_cnt++; if (cursor !== 4'd6) $display("FAIL move_down: got=%0d expected=6", cursor); else pass_cnt++;
        cur_model = 6;
        press(4);
        total_cnt++; if (selected !== 10'h016) $display("FAIL pick1_sel: got=%h expected=016", selected); else pass_cnt++;
        total_cnt++; if (logicMap[33] !== 1'b1) $display("FAIL pick1_reveal: got=%b expected=1", logicMap[33]); else pass_cnt++;
        // Picking the already-revealed first tile again must be ignored.
        press(4);
        total_cnt++; if (selected !== 10'h016 || busy !== 1'b0) $display("FAIL repick_ignored: sel=%h busy=%b expected 016/0", selected, busy); else pass_cnt++;
        $display("test_move_pick done");
    endtask

    task automatic test_match();
        goto(7);
        press(4);
        total_cnt++; if (selected !== 10'h2F6 || busy !== 1'b1) $display("FAIL pick2: sel=%h busy=%b expected 2f6/1", selected, busy); else pass_cnt++;
        total_cnt++; if (logicMap[39] !== 1'b0) $display("FAIL match_early: matched7=%b expected=0", logicMap[39]); else pass_cnt++;
        step();
        exp_pairs = 1;
        total_cnt++; if (logicMap[34] !== 1'b1 || logicMap[39] !== 1'b1) $display("FAIL match_bits: m6=%b m7=%b expected 1/1", logicMap[34], logicMap[39]); else pass_cnt++;
        total_cnt++; if (pairs_found !== 4'd1 || selected !== 10'd0 || busy !== 1'b0) $display("FAIL match_regs: pairs=%0d sel=%h busy=%b expected 1/0/0", pairs_found, selected, busy); else pass_cnt++;
        $display("test_match done");
    endtask

    task automatic test_corners();
        goto(0);
        press(2);
        total_cnt++;
`ifdef CURSOR_WRAP_EN
        cur_model = 3;
        if (cursor !== 4'd3) $display("FAIL left_edge: got=%0d expected=3", cursor); else pass_cnt++;
        goto(0);
`else
        if (cursor !== 4'd0) $display("FAIL left_edge: got=%0d expected=0", cursor); else pass_cnt++;
`endif
        btn_pick = 1; btn_right = 1; step(); btn_pick = 0; btn_right = 0;
        total_cnt++; if (cursor !== 4'd0 || selected !== 10'h010) $display("FAIL pick_with_move: cursor=%0d sel=%h expected 0/010", cursor, selected); else pass_cnt++;
        total_cnt++; if (logicMap[3] !== 1'b1) $display("FAIL pick_with_move_reveal: got=%b expected=1", logicMap[3]); else pass_cnt++;
        $display("test_corners done");
    endtask

    task automatic test_miss_show();
        goto(2);
        press(4); // now in COMPARE
        total_cnt++; if (selected !== 10'h250 || busy !== 1'b1) $display("FAIL miss_pick2: sel=%h busy=%b expected 250/1", selected, busy); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin btn_left = 1; btn_pick = 1; end
            step();
            btn_left = 0; btn_pick = 0;
            total_cnt++;
            if (logicMap[3] !== 1'b1 || logicMap[13] !== 1'b1 || busy !== 1'b1)
                $display("FAIL show_cycle%0d: r0=%b r2=%b busy=%b expected 1/1/1", k, logicMap[3], logicMap[13], busy);
            else pass_cnt++;
        end
        total_cnt++; if (cursor !== 4'd2 || selected !== 10'h250) $display("FAIL show_buttons: cursor=%0d sel=%h expected 2/250", cursor, selected); else pass_cnt++;
        step();
        total_cnt++; if (logicMap[3] !== 1'b0 || logicMap[13] !== 1'b0) $display("FAIL show_hide: r0=%b r2=%b expected 0/0", logicMap[3], logicMap[13]); else pass_cnt++;
        total_cnt++; if (selected !== 10'd0 || busy !== 1'b0) $display("FAIL show_end: sel=%h busy=%b expected 0/0", selected, busy); else pass_cnt++;
        $display("test_miss_show done");
    endtask

    task automatic solve_pair(input int a, input int b);
        goto(a); press(4);
        goto(b); press(4);
        step();
        exp_pairs++;
        total_cnt++;
        if (logicMap[5*a+4] !== 1'b1 || logicMap[5*b+4] !== 1'b1 || pairs_found !== 4'(exp_pairs) || busy !== 1'b0)
            $display("FAIL solve_%0d_%0d: ma=%b mb=%b pairs=%0d busy=%b expected 1/1/%0d/0", a, b, logicMap[5*a+4], logicMap[5*b+4], pairs_found, busy, exp_pairs);
        else pass_cnt++;
        $display("pair %0d/%0d solved", a, b);
    endtask

    task automatic test_solve();
        solve_pair(0, 1);
        solve_pair(2, 3);
        solve_pair(4, 5);
        solve_pair(8, 9);
        solve_pair(10, 11);
        solve_pair(12, 13);
        total_cnt++; if (game_done !== 1'b0) $display("FAIL not_done_yet: got=%b expected=0", game_done); else pass_cnt++;
        solve_pair(14, 15);
        total_cnt++; if (game_done !== 1'b1 || pairs_found !== 4'd8) $display("FAIL done: done=%b pairs=%0d expected 1/8", game_done, pairs_found); else pass_cnt++;
        press(2);
        total_cnt++; if (cursor !== 4'd15 || game_done !== 1'b1) $display("FAIL done_hold: cursor=%0d done=%b expected 15/1", cursor, game_done); else pass_cnt++;
        start = 1; step(); start = 0;
        cur_model = 0; exp_pairs = 0;
        total_cnt++; if (logicMap !== exp_map || pairs_found !== 4'd0 || game_done !== 1'b0 || cursor !== 4'd0) $display("FAIL restart: map=%h pairs=%0d done=%b cursor=%0d expected clean board", logicMap, pairs_found, game_done, cursor); else pass_cnt++;
        $display("test_solve done");
    endtask

    task automatic test_reset_mid_show();
        press(4);
        goto(2); press(4);
        step(); step(); // in SHOW
        total_cnt++; if (busy !== 1'b1) $display("FAIL pre_reset_busy: got=%b expected=1", busy); else pass_cnt++;
        reset = 1; #2;
        total_cnt++;
        if (logicMap !== 80'd0 || cursor !== 4'd0 || selected !== 10'd0 || pairs_found !== 4'd0 || busy !== 1'b0 || game_done !== 1'b0)
            $display("FAIL reset_mid_show: map=%h cursor=%0d sel=%h busy=%b expected all 0", logicMap, cursor, selected, busy);
        else pass_cnt++;
        step(); reset = 0; step();
        total_cnt++; if (logicMap !== 80'd0 || busy !== 1'b0) $display("FAIL idle_after_reset: map=%h busy=%b expected 0/0", logicMap, busy); else pass_cnt++;
        $display("test_reset_mid_show done");
    endtask

    initial begin
        reset = 1; start = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_pick = 0;
        for (int i = 0; i < 16; i++) begin
            init_colors[3*i +: 3] = 3'(i / 2);
            exp_map[5*i +: 5]     = {2'b00, 3'(i / 2)};
        end
        test_reset();
        test_start();
        test_move_pick();
        test_match();
        test_corners();
        test_miss_show();
        test_solve();
        test_reset_mid_show();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/map_controller.md
# map_controller

Game-logic writer for the 4x4 matching board. It owns the tile state vector, cursor and selection that the map display block reads. It consumes debounced single-cycle button pulses and runs the pick-two / compare / hide-on-miss loop. It sits between the button conditioning logic and the map display.

## Interface
- SHOW_CYCLES, 50_000_000: cycles both tiles of a mismatched pair stay revealed; must be ≥1.
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse; load a new board from init_colors and begin play
- init_colors  input  48  tile i color = init_colors[3i+2:3i]; caller guarantees each color appears exactly twice
- btn_up, btn_down, btn_left, btn_right, btn_pick  input  1 each  single-cycle pulses
- logicMap  output  80  tile i = logicMap[5i+4:5i], packed as {matched, revealed, color[2:0]}
- cursor  output  4  tile index, row*4+col
- selected  output  10  [4] first valid, [3:0] first index; [9] second valid, [8:5] second index
- pairs_found  output  4  matched pairs, 0..8
- busy  output  1  high in COMPARE and SHOW
- game_done  output  1  high in DONE

## Operation
- All outputs are registered. Reset values: logicMap=0, cursor=0, selected=0, pairs_found=0, busy=0, game_done=0, state=IDLE.
- States:
  - IDLE: waits for start.
  - PICK1 and PICK2: the player selects the first and second tile.
  - COMPARE: lasts exactly 1 cycle.
  - SHOW: counts down the display time after a miss.
  - DONE: the board is solved.
- start is accepted in every state and has top priority. On start:
  - every tile is loaded as {0,0,init_colors[3i+2:3i]}.
  - cursor=0, selected=0, pairs_found=0, show counter cleared.
  - next state is PICK1.
- Cursor movement is active only in PICK1 and PICK2; buttons are ignored in all other states.
  - If several move pulses arrive together, priority is up > down > left > right, and only one move is applied.
  - If btn_pick is high in the same cycle, the pick is processed at the current cursor and all moves are ignored.
  - up/down change the row by ∓1; left/right change the column by ∓1.
  - At an edge the cursor saturates (see Configuration for wrap mode).
- A tile is pickable when its matched=0 and revealed=0.
- PICK1:
  - btn_pick on a pickable tile sets revealed=1, sets selected[4:0]={1,cursor}, and moves to PICK2.
  - A pick on a non-pickable tile is ignored.
- PICK2:
  - btn_pick on a pickable tile sets revealed=1, sets selected[9:5]={1,cursor}, and moves to COMPARE.
  - The first tile is already revealed, so it cannot be picked again.
- COMPARE, colors equal:
  - set matched=1 on both tiles (revealed stays 1), pairs_found+1, selected=0.
  - go to DONE if the new pairs_found==8, otherwise go to PICK1.
- COMPARE, colors differ: load the counter with SHOW_CYCLES-1 and go to SHOW.
- SHOW:
  - decrement the counter each cycle.
  - in the cycle the counter is 0: clear revealed on both selected tiles, set selected=0, go to PICK1.
- DONE: game_done=1; the block holds until start or reset.
- The counter width is $clog2(SHOW_CYCLES+1). It must not wrap.

## Timing
- A move pulse in cycle N updates cursor at the edge ending cycle N.
- A pick in cycle N updates revealed and selected at the edge ending N. The state is PICK2 or COMPARE in N+1.
- A match: matched bits, pairs_found and selected=0 are all visible in cycle N+2 after the second pick.
- A miss: the tiles remain revealed for exactly SHOW_CYCLES cycles in SHOW. revealed and selected clear at the edge ending the last SHOW cycle.
- A pulse of start or reset mid-SHOW or mid-COMPARE aborts the operation immediately; no partial update is applied.
- Timing of busy: rises the cycle COMPARE is entered and falls the cycle PICK1 or DONE is entered.

## Configuration
- CURSOR_WRAP_EN:
  - when defined, a move past an edge wraps within the same row or column (col 3 + right → col 0; row 0 + up → row 3).
  - when undefined, the cursor saturates at the edge and no change occurs.

## Test plan
- Reset, then start with init_colors encoding tile i color = i/2 → logicMap[5i+4:5i] = {0,0,i/2} for all i; cursor=0; selected=0.
- From cursor 0: right, right, down, then pick → cursor=6; selected=10'h016; tile 6 revealed.
- Pick tile 0, then pick tile 1 (same color) → in cycle N+2 both matched=1, pairs_found=1, selected=0, busy back to 0.
- SHOW_CYCLES=4: pick tiles 0 and 2 (colors differ) → busy high, tiles revealed for exactly 4 SHOW cycles, then revealed=0 and state PICK1; buttons pressed during SHOW have no effect.
- Corner cases:
  - btn_pick together with btn_right → pick at the old cursor and no move.
  - picking the already-revealed first tile in PICK2 → ignored.
  - in saturate build, btn_left at col 0 → cursor unchanged; in the CURSOR_WRAP_EN build, btn_left at col 0 → col 3.
- Solve all 8 pairs → game_done=1 and pairs_found=8. A start pulse then clears everything; reset asserted mid-SHOW returns all outputs to 0.
